// File: rtl/spi_miso_tx_if.sv
// Transmit-buffer handshake and synchronized SPI pins of the MISO transmitter.
// The slave modport is the transmitter's own view of these signals.
interface spi_miso_tx_if #(
    parameter int WIDTH = 8
);
    logic             cs_sync;
    logic             sclk_sync;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             miso;
    logic             miso_oe;
    logic             tx_done;
    logic             underrun;

    modport slave (
        input  cs_sync, sclk_sync, tx_data, tx_valid,
        output tx_ready, miso, miso_oe, tx_done, underrun
    );

    modport master (
        output cs_sync, sclk_sync, tx_data, tx_valid,
        input  tx_ready, miso, miso_oe, tx_done, underrun
    );
endinterface

// File: rtl/spi_miso_tx.sv
// SPI mode-0 peripheral transmitter: shifts a buffered word out on MISO, MSB first.
// Works on chip-select and SCLK that are already synchronized into the clk domain.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | chip select high; MISO driven low, pad output disabled
//  ST_SHIFT | chip select low; bits leave on SCLK falls, counted on rises
module spi_miso_tx #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          en,
    spi_miso_tx_if.slave  spi
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_buf;
    logic             r_buf_full;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_word_done;
    logic             r_rise_seen;
    logic             r_cs_prev;
    logic             r_sclk_prev;
    logic             r_miso_oe;
    logic             r_tx_done;
    logic             r_underrun;

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_s_rise;
    logic w_s_fall;
    logic w_accept;
    logic w_load;

    assign w_cs_fall = r_cs_prev & ~spi.cs_sync;
    assign w_cs_rise = ~r_cs_prev & spi.cs_sync;
    assign w_s_rise  = ~r_sclk_prev & spi.sclk_sync;
    assign w_s_fall  = r_sclk_prev & ~spi.sclk_sync;
    assign w_accept  = spi.tx_valid & ~r_buf_full;

    // A new word enters the shifter at chip-select fall and at the first SCLK fall after a full word.
    assign w_load = ((r_state == ST_IDLE) & w_cs_fall) |
                    ((r_state == ST_SHIFT) & ~w_cs_rise & w_s_fall & r_word_done);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_rise_seen <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_tx_done   <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (en) begin
            r_cs_prev   <= spi.cs_sync;
            r_sclk_prev <= spi.sclk_sync;
            r_tx_done   <= 1'b0;
            r_underrun  <= 1'b0;

            if (w_accept) begin
                r_buf      <= spi.tx_data;
                r_buf_full <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_miso_oe <= w_cs_fall;
                    if (w_cs_fall) begin
                        r_state     <= ST_SHIFT;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                        r_rise_seen <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_miso_oe <= ~spi.cs_sync;
                    // Chip-select rise outranks any coincident SCLK edge.
                    if (w_cs_rise) begin
                        r_state     <= ST_IDLE;
                        r_bit_cnt   <= '0;
                        r_shift     <= '0;
                        r_word_done <= 1'b0;
                        r_rise_seen <= 1'b0;
                    end else if (w_s_rise) begin
                        r_rise_seen <= 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt   <= '0;
                            r_tx_done   <= 1'b1;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_s_fall) begin
                        if (r_word_done) begin
                            r_word_done <= 1'b0;
                        end else if (r_rise_seen) begin
                            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // An empty buffer at load time sends IDLE_WORD; a same-cycle accept still fills the buffer.
            if (w_load) begin
                if (r_buf_full) begin
                    r_shift    <= r_buf;
                    r_buf_full <= 1'b0;
                end else begin
                    r_shift    <= IDLE_WORD;
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    assign spi.tx_ready = ~r_buf_full;
    assign spi.miso     = r_shift[WIDTH-1];
    assign spi.miso_oe  = r_miso_oe;
    assign spi.tx_done  = r_tx_done;
    assign spi.underrun = r_underrun;
endmodule

// File: tb/tb_spi_miso_tx.sv
// Directed bench for spi_miso_tx: plays an SPI controller with 8-clk SCLK half-periods
// and compares the received bits and status pulses against hand-computed values.
module tb_spi_miso_tx;
    logic clk;
    logic rstb;
    logic en;

    spi_miso_tx_if #(.WIDTH(8)) bus ();

    spi_miso_tx #(.WIDTH(8), .IDLE_WORD(8'h00)) dut (
        .clk  (clk),
        .rstb (rstb),
        .en   (en),
        .spi  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int urun_cnt = 0;
    logic ready_low_seen = 1'b0;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.tx_done)   done_cnt++;
            if (bus.underrun)  urun_cnt++;
            if (!bus.tx_ready) ready_low_seen = 1'b1;
        end
    endtask

    task automatic clear_mon();
        done_cnt = 0;
        urun_cnt = 0;
        ready_low_seen = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
    endtask

    // Clocks nbits SCLK pulses; leaves SCLK high after the last one.
    task automatic xfer(input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int b = 0; b < nbits; b++) begin
            step(8);
            rx = {rx[14:0], bus.miso};
            bus.sclk_sync = 1'b1;
            step(8);
            if (b != nbits - 1) bus.sclk_sync = 1'b0;
        end
    endtask

    task automatic end_xfer();
        bus.cs_sync   = 1'b1;
        bus.sclk_sync = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        step(3);
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", bus.tx_ready); end
        checks++; if (bus.miso !== 1'b0)     begin errors++; $display("FAIL reset_miso got %b exp 0", bus.miso); end
        checks++; if (bus.miso_oe !== 1'b0)  begin errors++; $display("FAIL reset_miso_oe got %b exp 0", bus.miso_oe); end
        checks++; if (bus.tx_done !== 1'b0 || bus.underrun !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got done=%b urun=%b exp 0 0", bus.tx_done, bus.underrun);
        end
        rstb = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        logic [15:0] rx;
        clear_mon();
        load_word(8'hA5);
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL accept_ready_low got %b exp 0", bus.tx_ready); end
        bus.cs_sync = 1'b0;
        step(1);
        ready_low_seen = 1'b0;
        step(1);
        checks++; if (bus.miso !== 1'b1 || bus.miso_oe !== 1'b1) begin
            errors++; $display("FAIL first_bit_early got miso=%b oe=%b exp 1 1", bus.miso, bus.miso_oe);
        end
        xfer(8, rx);
        checks++; if (rx[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_word got %h exp a5", rx[7:0]); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_tx_done got %0d exp 1", done_cnt); end
        checks++; if (ready_low_seen) begin errors++; $display("FAIL basic_ready got low exp high throughout"); end
        end_xfer();
        checks++; if (urun_cnt != 0) begin errors++; $display("FAIL basic_underrun got %0d exp 0", urun_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx;
        clear_mon();
        load_word(8'h3C);
        bus.cs_sync = 1'b0;
        step(1);
        load_word(8'hC3);
        xfer(16, rx);
        end_xfer();
        checks++; if (rx !== 16'h3CC3) begin errors++; $display("FAIL b2b_words got %h exp 3cc3", rx); end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_tx_done got %0d exp 2", done_cnt); end
        checks++; if (urun_cnt != 0) begin errors++; $display("FAIL b2b_underrun got %0d exp 0", urun_cnt); end
    endtask

    task automatic test_underrun();
        logic [15:0] rx;
        clear_mon();
        bus.cs_sync = 1'b0;
        xfer(8, rx);
        end_xfer();
        checks++; if (urun_cnt != 1) begin errors++; $display("FAIL urun_count got %0d exp 1", urun_cnt); end
        checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL urun_word got %h exp 00", rx[7:0]); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL urun_tx_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_abort();
        logic [15:0] rx;
        clear_mon();
        load_word(8'hFF);
        bus.cs_sync = 1'b0;
        xfer(3, rx);
        end_xfer();
        checks++; if (rx[2:0] !== 3'b111) begin errors++; $display("FAIL abort_bits got %b exp 111", rx[2:0]); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_tx_done got %0d exp 0", done_cnt); end
        checks++; if (bus.miso !== 1'b0 || bus.miso_oe !== 1'b0) begin
            errors++; $display("FAIL abort_idle got miso=%b oe=%b exp 0 0", bus.miso, bus.miso_oe);
        end
        clear_mon();
        load_word(8'h81);
        bus.cs_sync = 1'b0;
        xfer(8, rx);
        end_xfer();
        checks++; if (rx[7:0] !== 8'h81) begin errors++; $display("FAIL abort_next_word got %h exp 81", rx[7:0]); end
        checks++; if (done_cnt != 1 || urun_cnt != 0) begin
            errors++; $display("FAIL abort_next_pulses got done=%0d urun=%0d exp 1 0", done_cnt, urun_cnt);
        end
    endtask

    task automatic test_enable_and_reset();
        logic [15:0] rx;
        clear_mon();
        en = 1'b0;
        bus.tx_data  = 8'h77;
        bus.tx_valid = 1'b1;
        bus.cs_sync  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(3);
            bus.sclk_sync = ~bus.sclk_sync;
        end
        step(3);
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL en0_accept got ready=%b exp 1", bus.tx_ready); end
        checks++; if (bus.miso_oe !== 1'b0 || bus.miso !== 1'b0) begin
            errors++; $display("FAIL en0_frozen got miso=%b oe=%b exp 0 0", bus.miso, bus.miso_oe);
        end
        checks++; if (done_cnt != 0 || urun_cnt != 0) begin
            errors++; $display("FAIL en0_pulses got done=%0d urun=%0d exp 0 0", done_cnt, urun_cnt);
        end
        bus.tx_valid  = 1'b0;
        bus.cs_sync   = 1'b1;
        bus.sclk_sync = 1'b0;
        step(1);
        en = 1'b1;
        step(2);
        checks++; if (bus.tx_ready !== 1'b1 || urun_cnt != 0) begin
            errors++; $display("FAIL en1_resume got ready=%b urun=%0d exp 1 0", bus.tx_ready, urun_cnt);
        end

        load_word(8'h99);
        bus.cs_sync = 1'b0;
        xfer(3, rx);
        bus.sclk_sync = 1'b0;
        step(8);
        load_word(8'h42);
        checks++; if (bus.miso !== 1'b1 || bus.tx_ready !== 1'b0) begin
            errors++; $display("FAIL midword_state got miso=%b ready=%b exp 1 0", bus.miso, bus.tx_ready);
        end
        #2;
        rstb = 1'b0;
        #1;
        checks++; if (bus.miso !== 1'b0 || bus.miso_oe !== 1'b0 || bus.tx_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset got miso=%b oe=%b ready=%b exp 0 0 1", bus.miso, bus.miso_oe, bus.tx_ready);
        end
        bus.cs_sync = 1'b1;
        step(2);
        rstb = 1'b1;
        step(2);
        checks++; if (bus.tx_ready !== 1'b1 || bus.tx_done !== 1'b0 || bus.underrun !== 1'b0) begin
            errors++; $display("FAIL after_reset got ready=%b done=%b urun=%b exp 1 0 0", bus.tx_ready, bus.tx_done, bus.underrun);
        end
    endtask

    task automatic test_valid_at_cs_fall();
        logic [15:0] rx;
        clear_mon();
        bus.tx_data  = 8'h5A;
        bus.tx_valid = 1'b1;
        bus.cs_sync  = 1'b0;
        step(1);
        bus.tx_valid = 1'b0;
        xfer(16, rx);
        end_xfer();
        checks++; if (rx !== 16'h005A) begin errors++; $display("FAIL coinc_words got %h exp 005a", rx); end
        checks++; if (urun_cnt != 1 || done_cnt != 2) begin
            errors++; $display("FAIL coinc_pulses got urun=%0d done=%0d exp 1 2", urun_cnt, done_cnt);
        end
    endtask

    initial begin
        rstb          = 1'b0;
        en            = 1'b1;
        bus.cs_sync   = 1'b1;
        bus.sclk_sync = 1'b0;
        bus.tx_data   = 8'h00;
        bus.tx_valid  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_enable_and_reset();
        test_valid_at_cs_fall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
